line_data_memory: RTL and testbench

//  Backing data memory behind dcache_top: serves 256-bit cache-line read/write requests
//  on the mem_* interface (enable/write/addr/data out, ack/data in) with a fixed,

---
 rtl/line_data_memory.sv | 153 +++++++++++++++
 tb/tb_line_data_memory.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_data_memory.sv
// -----------------------------------------------------------------------------
// line_data_memory
//   Backing line memory that sits behind the data cache. It serves one 256-bit
//   line read or write at a time and answers after a fixed, parameterised
//   latency. This models off-chip DRAM timing, so the cache stall path sees
//   realistic delays.
//
//   Optional feature (macro DMEM_RANGE_CHECK_EN):
//     When defined, the err_o port exists. An address with any bit set above the
//     line index is then flagged in the ack cycle. Such a write is dropped, and
//     such a read returns an all-zero line. When the macro is undefined, those
//     upper address bits are ignored and the address wraps.
//
// Parameters
//   LATENCY  clocks from request acceptance to ack_o (2..255)
//   DEPTH    number of 256-bit lines
//   IDX_W    line index width, clog2(DEPTH)
//
// Ports
//   clk_i     clock, all state on the rising edge
//   rst_i     asynchronous active-low reset
//   enable_i  request valid, sampled only while idle
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; bits [4:0] are ignored
//   data_i    line to write
//   ack_o     one-cycle completion strobe
//   data_o    last line read; it holds its value across writes
//   err_o     out-of-range flag in the ack cycle (DMEM_RANGE_CHECK_EN only)
// -----------------------------------------------------------------------------
module line_data_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic         err_o
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  // S_ACK is the single cycle after the commit. ack_o is registered out of
  // this state, so the strobe appears exactly LATENCY edges after acceptance.
  // The state machine is back in S_IDLE during the strobe cycle, so a request
  // held high through the ack is accepted LATENCY+1 clocks after the previous one.
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_write;
  logic [255:0]       r_wdata;
  logic [255:0]       r_mem [DEPTH];

  logic               w_commit;
  logic               w_bad;
  logic               w_unused_addr;

  // The counter holds the number of edges since acceptance. The commit happens
  // on the edge where it reads LATENCY-1, and the ack follows one edge later.
  assign w_commit = (r_state == S_BUSY) && (r_cnt == CNT_W'(LATENCY - 1));

  // Bits [4:0] select a byte within the line and never matter here. Without
  // the range check, the bits above the index are dropped as well.
  assign w_unused_addr = &{1'b0, addr_i[4:0], addr_i[31:IDX_W+5]};

`ifdef DMEM_RANGE_CHECK_EN
  logic r_oob;
  assign w_bad = r_oob;
`else
  assign w_bad = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so that every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      r_oob   <= 1'b0;
      err_o   <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err_o <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_idx   <= addr_i[IDX_W+4:5];
            r_write <= write_i;
            r_wdata <= data_i;
`ifdef DMEM_RANGE_CHECK_EN
            r_oob   <= |addr_i[31:IDX_W+5];
`endif
            r_cnt   <= CNT_W'(1);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_commit) begin
            r_cnt   <= '0;
            r_state <= S_ACK;
            if (!r_write) begin
              data_o <= w_bad ? '0 : r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACK: begin
          ack_o   <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
          err_o   <= r_oob;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Clearing 512 lines is not required,
  // and leaving the reset out lets the array map onto RAM. A reset that lands
  // mid-access forces the state machine to S_IDLE, so w_commit can never fire
  // for the aborted request.
  always_ff @(posedge clk_i) begin
    if (w_commit && r_write && !w_bad) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_line_data_memory.sv
module tb_line_data_memory;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;
  localparam int IDX_W = 9;

  logic         clk_i    = 1'b0;
  logic         rst_i    = 1'b0;
  logic         enable_i = 1'b0;
  logic         write_i  = 1'b0;
  logic [31:0]  addr_i   = '0;
  logic [255:0] data_i   = '0;
  logic         ack_o;
  logic [255:0] data_o;
`ifdef DMEM_RANGE_CHECK_EN
  logic         err_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model: a line-addressed array plus the value data_o should hold.
  logic [255:0] model_mem [DEPTH];
  logic [255:0] model_dout = '0;
  logic [31:0]  written_q [$];

  line_data_memory #(.LATENCY(LAT), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .err_o    (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 32) % DEPTH;
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a >= 32'(DEPTH * 32);
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Updates the model, issues one single-cycle request, scrambles the inputs
  // while busy, waits for ack (bounded), and checks latency, data, err, and
  // the one-cycle ack width.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                        input string name);
    int           lat;
    bit           exp_err;
    logic [255:0] exp_d;
    exp_err = out_of_range(addr);
    if (wr) begin
      if (!exp_err) begin
        model_mem[line_of(addr)] = wdata;
        written_q.push_back(addr % 32'(DEPTH * 32));
      end
      exp_d = model_dout;
    end else begin
      exp_d      = exp_err ? '0 : model_mem[line_of(addr)];
      model_dout = exp_d;
    end
    @(negedge clk_i);
    enable_i = 1'b1; write_i = wr; addr_i = addr; data_i = wdata;
    @(posedge clk_i);
    @(negedge clk_i);
    enable_i = 1'b0; write_i = $urandom_range(1); addr_i = $urandom; data_i = rand256();
    lat = 0;
    do begin
      @(posedge clk_i); lat++; @(negedge clk_i);
    end while (!ack_o && lat < 4 * LAT);
    total_cnt++;
    if (lat != LAT) $display("FAIL %s latency: got %0d clocks, expected %0d", name, lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (data_o !== exp_d) $display("FAIL %s data_o: got %h expected %h", name, data_o, exp_d);
    else pass_cnt++;
`ifdef DMEM_RANGE_CHECK_EN
    total_cnt++;
    if (err_o !== exp_err) $display("FAIL %s err_o: got %b expected %b", name, err_o, exp_err);
    else pass_cnt++;
`endif
    @(negedge clk_i);
    total_cnt++;
    if (ack_o !== 1'b0) $display("FAIL %s ack_width: ack_o got %b one cycle later, expected 0", name, ack_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    total_cnt++;
    if ({ack_o, data_o} !== '0) $display("FAIL reset outputs: ack_o=%b data_o=%h expected 0", ack_o, data_o);
    else pass_cnt++;
`ifdef DMEM_RANGE_CHECK_EN
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL reset err_o: got %b expected 0", err_o);
    else pass_cnt++;
`endif
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    total_cnt++;
    if (ack_o !== 1'b0) $display("FAIL idle ack_o: got %b expected 0", ack_o);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [255:0] d;
    d = {32{8'hA5}};
    access(1'b1, 32'h40, d, "basic_wr");
    access(1'b0, 32'h40, '0, "basic_rd");
  endtask

  task automatic test_wrap();
    logic [255:0] d;
    d = rand256();
    access(1'b1, 32'h40, d, "wrap_wr");
    access(1'b0, 32'h0000_4040, '0, "wrap_rd_alias");
    access(1'b1, 32'h0000_4040, rand256(), "wrap_wr_alias");
    access(1'b0, 32'h40, '0, "wrap_rd_line2");
  endtask

  task automatic test_edge_lines();
    access(1'b1, 32'(511 * 32), rand256(), "edge_wr511");
    access(1'b1, 32'h0, rand256(), "edge_wr0");
    access(1'b0, 32'(511 * 32), '0, "edge_rd511");
    access(1'b0, 32'h0, '0, "edge_rd0");
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          wr;
    for (int i = 0; i < 24; i++) begin
      wr = (written_q.size() == 0) || ($urandom_range(1) == 1);
      if (wr) a = {18'($urandom), IDX_W'($urandom), 5'($urandom)};
      else    a = written_q[$urandom_range(written_q.size() - 1)] | {27'd0, 5'($urandom)};
      if ($urandom_range(3) != 0) a[31:IDX_W+5] = '0;
      access(wr, a, rand256(), wr ? "rand_wr" : "rand_rd");
    end
  endtask

  task automatic test_reset_abort();
    logic [255:0] d1;
    bit           seen;
    d1 = rand256();
    access(1'b1, 32'h80, d1, "abort_pre_wr");
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h80; data_i = ~d1;
    @(posedge clk_i);
    @(negedge clk_i);
    enable_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total_cnt++;
    if ({ack_o, data_o} !== '0) $display("FAIL abort reset_outputs: ack_o=%b data_o=%h expected 0", ack_o, data_o);
    else pass_cnt++;
    model_dout = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk_i);
      if (ack_o) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL abort no_ack: ack_o got 1 after reset, expected 0");
    else pass_cnt++;
    access(1'b0, 32'h80, '0, "abort_rd_unchanged");
  endtask

  // Holds enable_i high through six requests. Request k+1 is presented in the
  // ack cycle of request k; acks must come every LAT+1 clocks.
  task automatic test_back_to_back();
    logic [255:0] exp_d [6];
    logic [31:0]  a;
    int           first_acc, last_ack, n;
    a = {18'd0, IDX_W'($urandom), 5'd0};
    last_ack = -1;
    @(negedge clk_i);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        n = 0;
        while (!ack_o && n < 4 * LAT) begin @(negedge clk_i); n++; end
        total_cnt++;
        if (data_o !== exp_d[k-1]) $display("FAIL b2b data_o req%0d: got %h expected %h", k - 1, data_o, exp_d[k-1]);
        else pass_cnt++;
        total_cnt++;
        if (last_ack < 0) begin
          if (cyc - first_acc != LAT) $display("FAIL b2b first_latency: got %0d expected %0d", cyc - first_acc, LAT);
          else pass_cnt++;
        end else begin
          if (cyc - last_ack != LAT + 1) $display("FAIL b2b spacing req%0d: got %0d expected %0d", k - 1, cyc - last_ack, LAT + 1);
          else pass_cnt++;
        end
        last_ack = cyc;
      end
      write_i  = (k % 2 == 0);
      enable_i = 1'b1;
      addr_i   = a + 32'((k / 2) * 32);
      data_i   = rand256();
      if (write_i) begin
        model_mem[line_of(addr_i)] = data_i;
        exp_d[k] = model_dout;
      end else begin
        model_dout = model_mem[line_of(addr_i)];
        exp_d[k]   = model_dout;
      end
      if (k == 0) first_acc = cyc + 1;
      else begin
        @(negedge clk_i);
        total_cnt++;
        if (ack_o !== 1'b0) $display("FAIL b2b double_ack after req%0d: ack_o got %b expected 0", k - 1, ack_o);
        else pass_cnt++;
      end
    end
    n = 0;
    while (!ack_o && n < 4 * LAT) begin @(negedge clk_i); n++; end
    enable_i = 1'b0;
    total_cnt++;
    if (cyc - last_ack != LAT + 1) $display("FAIL b2b spacing req5: got %0d expected %0d", cyc - last_ack, LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (data_o !== exp_d[5]) $display("FAIL b2b data_o req5: got %h expected %h", data_o, exp_d[5]);
    else pass_cnt++;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_edge_lines();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
